// File: rtl/data_switch_buf.sv
// Readout data switch with a DEPTH-entry buffer between the hit formatter and the output FIFO.
// Define DATA_SWITCH_TMR_EN to triplicate the count and pointer registers with majority voting.
module data_switch_buf #(
  parameter int                WORD_W  = 12,
  parameter int                NWORDS  = 3,
  parameter int                HDR_W   = 24,
  parameter logic [WORD_W-1:0] TRAILER = 12'hEC5,
  parameter int                DEPTH   = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     ID_nData,
  input  logic [NWORDS*WORD_W-1:0] Words,
  input  logic [HDR_W-1:0]         Header,
  input  logic                     winc_in,
  output logic                     FullOut,
  output logic [NWORDS*WORD_W-1:0] FifoIn,
  output logic                     winc_out,
  input  logic                     Full,
  output logic                     DropErr,
  output logic [7:0]               DropCnt
);

  localparam int FW = NWORDS * WORD_W;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_v, rd_v, wr_n, rd_n;
  logic [CW-1:0] cnt_v, cnt_n;
  logic          push, pop, refuse;
  logic [FW-1:0] entry;
  logic [FW-1:0] mem [DEPTH];
  logic [FW-1:0] hold_q;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    push   = winc_in & ~FullOut;
    refuse = winc_in & FullOut;
    pop    = winc_out;
    entry  = ID_nData ? {Header, TRAILER} : Words;
    wr_n   = wr_v;
    rd_n   = rd_v;
    cnt_n  = cnt_v;
    if (push) wr_n = wr_v + AW'(1);
    if (pop)  rd_n = rd_v + AW'(1);
    case ({push, pop})
      2'b10:   cnt_n = cnt_v + CW'(1);
      2'b01:   cnt_n = cnt_v - CW'(1);
      default: cnt_n = cnt_v;
    endcase
  end

  // Outputs depend only on registered state and the downstream Full, never on the write inputs.
  assign winc_out = (cnt_v != '0) & ~Full;
  assign FullOut  = (cnt_v == CW'(DEPTH));
  assign FifoIn   = (cnt_v != '0) ? mem[rd_v] : hold_q;

`ifdef DATA_SWITCH_TMR_EN
  logic [CW-1:0] count_r0, count_r1, count_r2;
  logic [AW-1:0] wr_ptr_r0, wr_ptr_r1, wr_ptr_r2;
  logic [AW-1:0] rd_ptr_r0, rd_ptr_r1, rd_ptr_r2;

  // Bitwise 2-of-3 vote; every copy reloads from the voted value, so one upset heals in a cycle.
  assign cnt_v = (count_r0 & count_r1) | (count_r0 & count_r2) | (count_r1 & count_r2);
  assign wr_v  = (wr_ptr_r0 & wr_ptr_r1) | (wr_ptr_r0 & wr_ptr_r2) | (wr_ptr_r1 & wr_ptr_r2);
  assign rd_v  = (rd_ptr_r0 & rd_ptr_r1) | (rd_ptr_r0 & rd_ptr_r2) | (rd_ptr_r1 & rd_ptr_r2);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count_r0  <= '0;
      count_r1  <= '0;
      count_r2  <= '0;
      wr_ptr_r0 <= '0;
      wr_ptr_r1 <= '0;
      wr_ptr_r2 <= '0;
      rd_ptr_r0 <= '0;
      rd_ptr_r1 <= '0;
      rd_ptr_r2 <= '0;
    end else begin
      count_r0  <= cnt_n;
      count_r1  <= cnt_n;
      count_r2  <= cnt_n;
      wr_ptr_r0 <= wr_n;
      wr_ptr_r1 <= wr_n;
      wr_ptr_r2 <= wr_n;
      rd_ptr_r0 <= rd_n;
      rd_ptr_r1 <= rd_n;
      rd_ptr_r2 <= rd_n;
    end
  end
`else
  logic [CW-1:0] count_r;
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;

  assign cnt_v = count_r;
  assign wr_v  = wr_ptr_r;
  assign rd_v  = rd_ptr_r;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      count_r  <= cnt_n;
      wr_ptr_r <= wr_n;
      rd_ptr_r <= rd_n;
    end
  end
`endif

  // hold_q tracks the head entry so FifoIn keeps the last popped word once the buffer empties.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hold_q  <= '0;
      DropErr <= 1'b0;
      DropCnt <= '0;
    end else begin
      if (cnt_v != '0) hold_q <= mem[rd_v];
      if (refuse) begin
        DropErr <= 1'b1;
        if (DropCnt != 8'hFF) DropCnt <= DropCnt + 8'd1;
      end
    end
  end

  // NOTE: the storage array has no reset; entries are only read once count marks them valid.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_v] <= entry;
  end

endmodule

// File: tb/tb_data_switch_buf.sv
// Directed bench for data_switch_buf: a per-cycle model of occupancy plus a scoreboard queue
// that is filled on accepted pushes and drained on every winc_out strobe.
module tb_data_switch_buf;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ID_nData;
  logic [35:0] Words;
  logic [23:0] Header;
  logic        winc_in;
  logic        FullOut;
  logic [35:0] FifoIn;
  logic        winc_out;
  logic        Full;
  logic        DropErr;
  logic [7:0]  DropCnt;

  data_switch_buf dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ID_nData (ID_nData),
    .Words    (Words),
    .Header   (Header),
    .winc_in  (winc_in),
    .FullOut  (FullOut),
    .FifoIn   (FifoIn),
    .winc_out (winc_out),
    .Full     (Full),
    .DropErr  (DropErr),
    .DropCnt  (DropCnt)
  );

  always #5 Clk = ~Clk;

  int          n_assert  = 0;
  int          n_fail    = 0;
  int          mcount    = 0;
  int          exp_drops = 0;
  int          n_strobes = 0;
  logic [35:0] sb [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sat_drops(input int d);
    return (d > 255) ? 8'hFF : 8'(d);
  endfunction

  // One clock of stimulus, entered and left at posedge+1; checks handshake outputs on the negedge.
  task automatic cycle(input bit w, input bit idn, input logic [35:0] wd,
                       input logic [23:0] hd, input bit full);
    bit push_ok, pop_ok;
    winc_in  = w;
    ID_nData = idn;
    Words    = wd;
    Header   = hd;
    Full     = full;
    @(negedge Clk);
    check("full_out", FullOut, (mcount == DEPTH));
    check("winc_out", winc_out, (mcount != 0) && !full);
    push_ok = w && (mcount != DEPTH);
    pop_ok  = (mcount != 0) && !full;
    if (push_ok) sb.push_back(idn ? {hd, 12'hEC5} : wd);
    if (w && !push_ok) exp_drops++;
    @(posedge Clk);
    #1;
    mcount = mcount + int'(push_ok) - int'(pop_ok);
    winc_in = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sb.size() != 0; i++) cycle(0, 0, '0, '0, 0);
    check("drain_empty", sb.size(), 0);
  endtask

  always @(negedge Clk) begin
    logic [35:0] exp_w;
    if (Reset === 1'b1 && winc_out === 1'b1) begin
      n_strobes++;
      if (sb.size() == 0) check("strobe_while_empty", winc_out, 1'b0);
      else begin
        exp_w = sb.pop_front();
        check("sb_data", FifoIn, exp_w);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s0;
    logic [35:0] w0;
    logic [35:0] rw;
    Reset = 1'b0; ID_nData = 1'b0; Words = '0; Header = '0; winc_in = 1'b0; Full = 1'b0;
    #2;
    check("rst_full_out", FullOut, 1'b0);
    check("rst_winc_out", winc_out, 1'b0);
    check("rst_fifo_in", FifoIn, 36'h0);
    check("rst_drop_err", DropErr, 1'b0);
    check("rst_drop_cnt", DropCnt, 8'h00);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;

    // Single data entry, visible the cycle after the push, then held after the pop.
    cycle(1, 0, 36'h123456789, '0, 0);
    check("first_fifo_in", FifoIn, 36'h123456789);
    check("first_winc_out", winc_out, 1'b1);
    cycle(0, 0, '0, '0, 0);
    check("hold_after_pop", FifoIn, 36'h123456789);

    // Header entry formatted with the trailer.
    cycle(1, 1, 36'hFFFFFFFFF, 24'hABCDEF, 0);
    check("hdr_fifo_in", FifoIn, 36'hABCDEFEC5);
    cycle(0, 0, '0, '0, 0);

    // Downstream full: four accepted, fifth refused; then a push at full coinciding with a pop.
    s0 = n_strobes;
    w0 = 36'h111111111;
    for (int i = 0; i < 5; i++) cycle(1, 0, w0 + 36'(i), '0, 1);
    check("stable_under_full", FifoIn, w0);
    check("drop_err_set", DropErr, 1'b1);
    check("drop_cnt_one", DropCnt, 8'd1);
    cycle(1, 0, 36'h222222222, '0, 0);
    check("drop_cnt_two", DropCnt, sat_drops(exp_drops));
    drain();
    check("full_release_strobes", n_strobes - s0, 4);

    // Full throughput with Full toggling every three cycles, mixed header/data entries.
    for (int i = 0; i < 40; i++) begin
      rw = 36'({$urandom(), $urandom()});
      cycle(1, (i % 5) == 0, rw, 24'($urandom()), ((i / 3) % 2) == 1);
    end
    drain();
    check("tput_drop_cnt", DropCnt, sat_drops(exp_drops));

    // Drop counter saturates at 255.
    for (int i = 0; i < 262; i++) cycle(1, 0, 36'(i), '0, 1);
    check("sat_drop_cnt", DropCnt, sat_drops(exp_drops));
    check("sat_drop_err", DropErr, 1'b1);
    drain();

    // Reset with three entries buffered.
    for (int i = 0; i < 3; i++) cycle(1, 0, 36'h300000000 + 36'(i), '0, 1);
    Reset = 1'b0;
    #1;
    check("midrst_winc_out", winc_out, 1'b0);
    check("midrst_full_out", FullOut, 1'b0);
    check("midrst_fifo_in", FifoIn, 36'h0);
    check("midrst_drop_err", DropErr, 1'b0);
    check("midrst_drop_cnt", DropCnt, 8'h00);
    sb.delete();
    mcount    = 0;
    exp_drops = 0;
    @(posedge Clk);
    #1 Reset = 1'b1;
    s0 = n_strobes;
    for (int i = 0; i < 6; i++) cycle(0, 0, '0, '0, 0);
    check("no_strobe_after_reset", n_strobes - s0, 0);
    cycle(1, 1, '0, 24'h5A5A5A, 0);
    drain();

`ifdef DATA_SWITCH_TMR_EN
    // Upset one count copy; outputs must follow the voted count and the copy must heal.
    cycle(1, 0, 36'h444444444, '0, 1);
    cycle(1, 0, 36'h555555555, '0, 1);
    force dut.count_r1 = 3'd0;
    #1 release dut.count_r1;
    cycle(1, 0, 36'h666666666, '0, 1);
    check("tmr_copy_healed", dut.count_r1, 3'(mcount));
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
